// File: rtl/axi4_lite_master_pkg.sv
// System definitions for axi4_lite_master: bus widths, FSM state encodings and AXI response codes.
// ADDR_W / DATA_W may be overridden with +define+ before this file is compiled.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

package axi4_lite_master_pkg;

  localparam int ADDR_W = `ADDR_W;
  localparam int DATA_W = `DATA_W;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  // Anything other than OKAY is reported to the CPU as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master bridging a simple CPU request/response port onto the bus.
// Optional: define AXIM_ALIGN_CHECK_EN to reject word-misaligned requests locally.
module axi4_lite_master
  import axi4_lite_master_pkg::*;
(
  input  logic              ACLK,
  input  logic              ARESETn,
  // CPU side
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  input  logic [STRB_W-1:0] REQ_WSTRB,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  // AW channel
  output logic              AW_VALID,
  input  logic              AW_READY,
  output logic [ADDR_W-1:0] AW_ADDR,
  // W channel
  output logic              W_VALID,
  input  logic              W_READY,
  output logic [DATA_W-1:0] W_DATA,
  output logic [STRB_W-1:0] W_STRB,
  // B channel
  input  logic              B_VALID,
  output logic              B_READY,
  input  logic [1:0]        B_RESP,
  // AR channel
  output logic              AR_VALID,
  input  logic              AR_READY,
  output logic [ADDR_W-1:0] AR_ADDR,
  // R channel
  input  logic              R_VALID,
  output logic              R_READY,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP
);

  state_t state_reg, state_next;

  logic              aw_valid_reg;
  logic              w_valid_reg;
  logic              ar_valid_reg;
  logic [ADDR_W-1:0] aw_addr_reg;
  logic [ADDR_W-1:0] ar_addr_reg;
  logic [DATA_W-1:0] w_data_reg;
  logic [STRB_W-1:0] w_strb_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;

  logic req_fire;
  logic addr_bad;
  logic aw_done;
  logic w_done;

  assign req_fire = REQ_VALID && (state_reg == IDLE);

`ifdef AXIM_ALIGN_CHECK_EN
  assign addr_bad = (REQ_ADDR[1:0] != 2'b00);
`else
  assign addr_bad = 1'b0;
`endif

  // A channel counts as finished if it already handshook or handshakes this cycle.
  assign aw_done = !aw_valid_reg || AW_READY;
  assign w_done  = !w_valid_reg  || W_READY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_fire && !addr_bad) begin
          state_next = REQ_WE ? WRITE : RADDR;
        end
      end
      WRITE: begin
        if (aw_done && w_done) begin
          state_next = WRESP;
        end
      end
      WRESP: begin
        if (B_VALID) begin
          state_next = IDLE;
        end
      end
      RADDR: begin
        if (AR_READY) begin
          state_next = RDATA;
        end
      end
      RDATA: begin
        if (R_VALID) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Channel and response registers; W_DATA/W_STRB/addresses hold until the next accepted request.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_valid_reg  <= 1'b0;
      w_valid_reg   <= 1'b0;
      ar_valid_reg  <= 1'b0;
      aw_addr_reg   <= '0;
      ar_addr_reg   <= '0;
      w_data_reg    <= '0;
      w_strb_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_fire) begin
            if (addr_bad) begin
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
            end else if (REQ_WE) begin
              aw_valid_reg <= 1'b1;
              w_valid_reg  <= 1'b1;
              aw_addr_reg  <= REQ_ADDR;
              w_data_reg   <= REQ_WDATA;
              w_strb_reg   <= REQ_WSTRB;
            end else begin
              ar_valid_reg <= 1'b1;
              ar_addr_reg  <= REQ_ADDR;
            end
          end
        end
        WRITE: begin
          if (AW_READY) begin
            aw_valid_reg <= 1'b0;
          end
          if (W_READY) begin
            w_valid_reg <= 1'b0;
          end
        end
        WRESP: begin
          if (B_VALID) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= resp_is_err(B_RESP);
            rsp_rdata_reg <= '0;
          end
        end
        RADDR: begin
          if (AR_READY) begin
            ar_valid_reg <= 1'b0;
          end
        end
        RDATA: begin
          if (R_VALID) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= resp_is_err(R_RESP);
            rsp_rdata_reg <= R_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign REQ_READY = (state_reg == IDLE);
  assign B_READY   = (state_reg == WRESP);
  assign R_READY   = (state_reg == RDATA);

  assign AW_VALID  = aw_valid_reg;
  assign AW_ADDR   = aw_addr_reg;
  assign W_VALID   = w_valid_reg;
  assign W_DATA    = w_data_reg;
  assign W_STRB    = w_strb_reg;
  assign AR_VALID  = ar_valid_reg;
  assign AR_ADDR   = ar_addr_reg;

  assign RSP_VALID = rsp_valid_reg;
  assign RSP_ERR   = rsp_err_reg;
  assign RSP_RDATA = rsp_rdata_reg;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: table of bus transactions with a delay-programmable
// slave, a response scoreboard, plus hand sequences for reset abort and stray B/R traffic.
module tb_axi4_lite_master;
  import axi4_lite_master_pkg::*;

`ifdef AXIM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic              REQ_VALID = 1'b0;
  logic              REQ_READY;
  logic              REQ_WE = 1'b0;
  logic [ADDR_W-1:0] REQ_ADDR = '0;
  logic [DATA_W-1:0] REQ_WDATA = '0;
  logic [STRB_W-1:0] REQ_WSTRB = '0;
  logic              RSP_VALID;
  logic [DATA_W-1:0] RSP_RDATA;
  logic              RSP_ERR;
  logic              AW_VALID;
  logic              AW_READY = 1'b0;
  logic [ADDR_W-1:0] AW_ADDR;
  logic              W_VALID;
  logic              W_READY = 1'b0;
  logic [DATA_W-1:0] W_DATA;
  logic [STRB_W-1:0] W_STRB;
  logic              B_VALID = 1'b0;
  logic              B_READY;
  logic [1:0]        B_RESP = 2'b00;
  logic              AR_VALID;
  logic              AR_READY = 1'b0;
  logic [ADDR_W-1:0] AR_ADDR;
  logic              R_VALID = 1'b0;
  logic              R_READY;
  logic [DATA_W-1:0] R_DATA = '0;
  logic [1:0]        R_RESP = 2'b00;

  always #5 ACLK = ~ACLK;

  axi4_lite_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  // a_dly: cycles AW/AR waits for ready; w_dly: same for W; r_dly: cycles before B/R valid.
  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    int                a_dly;
    int                w_dly;
    int                r_dly;
    logic [1:0]        resp;
    logic [DATA_W-1:0] rdata;
  } vec_t;
  localparam int NVEC = 7;
  vec_t vecs[NVEC];

  logic [DATA_W-1:0] last_wdata = '0;
  bit                have_w = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_slave();
    AW_READY = 1'b0;
    W_READY  = 1'b0;
    AR_READY = 1'b0;
    B_VALID  = 1'b0;
    R_VALID  = 1'b0;
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge where the response is seen.
  task automatic run_vec(input int idx, input vec_t v);
    int   aw_hs = 0, w_hs = 0, ar_hs = 0;
    int   a_cnt = 0, w_cnt = 0, r_cnt = 0;
    bit   got = 1'b0;
    bit   mis;
    bit   wphase, rphase;
    exp_t e, g;
    mis = ALIGN_EN && (v.addr[1:0] != 2'b00);
    chk("req_ready_idle", 64'(REQ_READY), 64'(1));
    REQ_VALID = 1'b1;
    REQ_WE    = v.we;
    REQ_ADDR  = v.addr;
    REQ_WDATA = v.wdata;
    REQ_WSTRB = v.wstrb;
    e.err   = mis ? 1'b1 : (v.resp != RESP_OKAY);
    e.rdata = (mis || v.we) ? '0 : v.rdata;
    exp_q.push_back(e);
    @(negedge ACLK);
    REQ_VALID = 1'b0;
    REQ_WDATA = $urandom;
    REQ_WSTRB = '0;
    if (!mis) begin
      if (v.we) chk("aw_w_valid_first", 64'({AW_VALID, W_VALID}), 64'(2'b11));
      else      chk("ar_valid_first", 64'(AR_VALID), 64'(1));
    end else begin
      chk("no_axi_on_misaligned", 64'({AW_VALID, W_VALID, AR_VALID}), 64'(0));
    end
    if (!v.we && have_w) chk("w_data_hold", 64'(W_DATA), 64'(last_wdata));
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (RSP_VALID) begin
        chk("req_ready_with_rsp", 64'(REQ_READY), 64'(1));
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(1), 64'(0));
        end else begin
          g = exp_q.pop_front();
          chk("rsp_err", 64'(RSP_ERR), 64'(g.err));
          chk("rsp_rdata", 64'(RSP_RDATA), 64'(g.rdata));
        end
        got = 1'b1;
        break;
      end
      // Response-phase readiness is judged from handshakes decided in earlier cycles.
      wphase = v.we && (aw_hs > 0) && (w_hs > 0);
      rphase = !v.we && (ar_hs > 0);
      chk("b_ready_gate", 64'(B_READY), 64'(wphase));
      chk("r_ready_gate", 64'(R_READY), 64'(rphase));
      if (wphase) begin
        B_VALID = (r_cnt >= v.r_dly);
        B_RESP  = v.resp;
        r_cnt++;
      end
      if (rphase) begin
        R_VALID = (r_cnt >= v.r_dly);
        R_RESP  = v.resp;
        R_DATA  = v.rdata;
        r_cnt++;
      end
      if (AW_VALID) begin
        chk("aw_addr", 64'(AW_ADDR), 64'(v.addr));
        AW_READY = (a_cnt >= v.a_dly);
        if (AW_READY) aw_hs++;
        a_cnt++;
      end else begin
        AW_READY = 1'b0;
      end
      if (W_VALID) begin
        chk("w_data", 64'(W_DATA), 64'(v.wdata));
        chk("w_strb", 64'(W_STRB), 64'(v.wstrb));
        W_READY = (w_cnt >= v.w_dly);
        if (W_READY) w_hs++;
        w_cnt++;
      end else begin
        W_READY = 1'b0;
      end
      if (AR_VALID) begin
        chk("ar_addr", 64'(AR_ADDR), 64'(v.addr));
        AR_READY = (a_cnt >= v.a_dly);
        if (AR_READY) ar_hs++;
        a_cnt++;
      end else begin
        AR_READY = 1'b0;
      end
      @(negedge ACLK);
    end
    chk("rsp_timeout", 64'(got), 64'(1));
    clear_slave();
    chk("aw_count", 64'(aw_hs), 64'((v.we && !mis) ? 1 : 0));
    chk("w_count", 64'(w_hs), 64'((v.we && !mis) ? 1 : 0));
    chk("ar_count", 64'(ar_hs), 64'((!v.we && !mis) ? 1 : 0));
    if (v.we && !mis) begin
      last_wdata = v.wdata;
      have_w     = 1'b1;
    end
    $display("txn %0d %s addr=%h err=%0b rdata=%h", idx, v.we ? "WR" : "RD", v.addr, RSP_ERR, RSP_RDATA);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            we    addr      wdata         strb  a  w  r  resp         rdata
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2, RESP_OKAY,   32'h0};
    vecs[1] = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 1, RESP_OKAY,   32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h20, 32'hCAFEF00D, 4'h3, 0, 5, 0, RESP_OKAY,   32'h0};
    vecs[3] = '{1'b0, 32'h24, 32'h0,        4'h0, 2, 0, 0, RESP_SLVERR, 32'h12345678};
    vecs[4] = '{1'b1, 32'h30, 32'h55AA55AA, 4'h0, 3, 0, 1, RESP_SLVERR, 32'h0};
    vecs[5] = '{1'b1, 32'h34, 32'h0BADF00D, 4'hC, 2, 2, 0, RESP_OKAY,   32'h0};
    vecs[6] = '{1'b0, 32'h13, 32'h0,        4'h0, 0, 0, 0, RESP_OKAY,   32'hA5A5A5A5};

    // Reset state
    repeat (2) @(negedge ACLK);
    chk("rst_aw_valid", 64'(AW_VALID), 64'(0));
    chk("rst_w_valid", 64'(W_VALID), 64'(0));
    chk("rst_ar_valid", 64'(AR_VALID), 64'(0));
    chk("rst_readies", 64'({B_READY, R_READY}), 64'(0));
    chk("rst_rsp", 64'({RSP_VALID, RSP_ERR}), 64'(0));
    chk("rst_rsp_rdata", 64'(RSP_RDATA), 64'(0));
    chk("rst_addrs", 64'({AW_ADDR, AR_ADDR}), 64'(0));
    chk("rst_w_data", 64'(W_DATA), 64'(0));
    chk("rst_w_strb", 64'(W_STRB), 64'(0));
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("req_ready_after_reset", 64'(REQ_READY), 64'(1));

    // Table, issued back-to-back
    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Stray B/R while idle must be ignored
    @(negedge ACLK);
    B_VALID = 1'b1;
    R_VALID = 1'b1;
    B_RESP  = RESP_SLVERR;
    R_RESP  = RESP_SLVERR;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("stray_readies_low", 64'({B_READY, R_READY}), 64'(0));
      chk("stray_no_rsp", 64'(RSP_VALID), 64'(0));
      chk("stray_req_ready", 64'(REQ_READY), 64'(1));
    end
    clear_slave();
    $display("txn stray B/R while idle done");

    // Reset asserted while AR waits on AR_READY=0
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b0;
    REQ_ADDR  = 32'h40;
    @(negedge ACLK);
    REQ_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ar_valid_waiting", 64'(AR_VALID), 64'(1));
      @(negedge ACLK);
    end
    #2 ARESETn = 1'b0;
    #1;
    chk("ar_valid_async_clear", 64'(AR_VALID), 64'(0));
    chk("ar_addr_async_clear", 64'(AR_ADDR), 64'(0));
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    have_w  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("abort_no_rsp", 64'(RSP_VALID), 64'(0));
      chk("abort_req_ready", 64'(REQ_READY), 64'(1));
    end
    $display("txn reset abort of pending read done");

    // Normal operation resumes after the abort
    run_vec(NVEC, vecs[0]);
    run_vec(NVEC + 1, vecs[3]);
    @(negedge ACLK);
    chk("rsp_one_cycle", 64'(RSP_VALID), 64'(0));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
